alien_wave_sequencer: RTL and testbench
=======================================

// Module: alien_wave_sequencer
// PURPOSE
//  Game-phase scheduler for the alien formation: starts waves, pulses a formation reset, and paces the march.
//  Emits move_tick to the formation block; the interval shrinks as aliens die and as wave number rises.
//  Tracks kills via shot_hit, ends a wave on last kill, and holds the game in LOST on formation game_over.
//  Sits between the top-level game FSM/buttons and the alien formation controller.
// PARAMETERS
//  N_ALIENS       15       aliens per wave (3x5 formation)
//  BASE_INTERVAL  800000   clk cycles between moves at wave 0, all alive
//  KILL_STEP      40000    interval reduction per alien killed this wave
//  WAVE_STEP      100000   interval reduction per completed wave
//  MIN_INTERVAL   50000    interval floor
//  CLEAR_FRAMES   120      frame_ticks of pause between waves
//  WAVE_W         4        wave counter width (saturates at all-ones)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high
//  start            in   1   level; begin game from IDLE/LOST (rising edge detected internally)
//  frame_tick       in   1   1-cycle pulse per video frame
//  shot_hit         in   1   1-cycle pulse: formation reports an alien killed
//  formation_over   in   1   formation reached bottom (level, from formation game_over)
//  formation_reset  out  1   1-cycle pulse: respawn formation at start position
//  move_tick        out  1   1-cycle pulse: advance formation one step
//  alive_count      out  5   aliens remaining this wave
//  wave_num         out  WAVE_W  completed waves
//  interval         out  22  current move interval (cycles)
//  playing          out  1   high in PLAY only
//  lost             out  1   high in LOST only
// BEHAVIOUR
//  Reset: state=IDLE; formation_reset=0, move_tick=0, alive_count=N_ALIENS, wave_num=0,
//   interval=BASE_INTERVAL, playing=0, lost=0; move counter, pause counter, start-edge reg cleared.
//  States: IDLE -> SPAWN on start rising edge; SPAWN -> PLAY after 1 cycle;
//   PLAY -> CLEAR when alive_count reaches 0; PLAY -> LOST when formation_over=1;
//   CLEAR -> SPAWN after CLEAR_FRAMES frame_ticks; LOST -> SPAWN on start rising edge (wave_num:=0).
//  SPAWN: formation_reset=1 for exactly that cycle; alive_count:=N_ALIENS; move counter:=0.
//  PLAY: move counter increments each clk; when counter >= interval-1, move_tick=1 next cycle, counter:=0.
//   move_tick never asserted outside PLAY. Counter >= interval after interval shrinks -> immediate tick.
//  shot_hit in PLAY: alive_count -= 1, saturating at 0; shot_hit outside PLAY ignored.
//  interval registered, updated the cycle after alive_count/wave_num change:
//   BASE_INTERVAL - (N_ALIENS-alive_count)*KILL_STEP - wave_num*WAVE_STEP, computed in 24-bit signed,
//   clamped to MIN_INTERVAL when result < MIN_INTERVAL (including negative).
//  CLEAR entry: wave_num += 1 (saturating); pause counter:=0, counts frame_ticks only.
//  Simultaneous shot_hit killing last alien and formation_over same cycle: LOST wins; count still decrements.
//  formation_over ignored outside PLAY (it stays high until formation_reset clears it upstream).
//  start held high does not retrigger: needs low->high edge. start in PLAY/CLEAR/SPAWN ignored.
//  reset mid-wave: returns to IDLE next edge; no formation_reset pulse emitted by reset itself.
//  All outputs registered; no combinational input->output paths.
// STRUCTURE
//  Shared package/header: state encoding (IDLE,SPAWN,PLAY,CLEAR,LOST), N_ALIENS, interval constants,
//   shared with the formation controller and top-level so both agree on formation size.
//  One sub-module natural: move_pacer (programmable-interval tick generator: clk, reset, enable,
//   interval[21:0] -> tick). Interval arithmetic and FSM stay in this module.
// TESTING
//  Use small params (BASE 100, KILL_STEP 5, WAVE_STEP 10, MIN 20, CLEAR_FRAMES 3) for speed.
//  T1 reset then start pulse -> formation_reset 1 cycle, playing=1, move_tick every 100 clks, alive_count=15.
//  T2 4 shot_hit pulses in PLAY -> alive_count=11, interval=80 one cycle later, tick spacing 80.
//  T3 15 hits -> CLEAR, wave_num=1, no move_tick; after 3 frame_ticks -> formation_reset, interval=90.
//  T4 formation_over in PLAY -> lost=1, move_tick stops; start held high no restart; low->high -> SPAWN, wave_num=0.
//  T5 wave_num=9 and 14 kills -> raw interval negative -> interval=20 (floor).
//  T6 last-kill shot_hit with formation_over same cycle -> LOST, alive_count=0; reset in PLAY -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/alien_wave_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : alien_wave_sequencer_pkg
// Brief  : Shared definitions for the alien wave sequencer, the formation
//          controller and the top-level game logic. All of them import the
//          formation size and pacing constants from here, so they always
//          agree on them.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   wave_state_t     game-phase state encoding (IDLE, SPAWN, PLAY, CLEAR, LOST)
//   AWS_*            formation size and interval/pause constants
// ============================================================================
package alien_wave_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_LOST  = 3'd4
  } wave_state_t;

  localparam int AWS_N_ALIENS      = 15;      // 3x5 formation
  localparam int AWS_BASE_INTERVAL = 800000;
  localparam int AWS_KILL_STEP     = 40000;
  localparam int AWS_WAVE_STEP     = 100000;
  localparam int AWS_MIN_INTERVAL  = 50000;
  localparam int AWS_CLEAR_FRAMES  = 120;
  localparam int AWS_WAVE_W        = 4;

  localparam int AWS_ALIVE_W    = 5;
  localparam int AWS_INTERVAL_W = 22;
  // Wide enough that the most negative raw interval stays representable.
  localparam int AWS_CALC_W     = 24;

endpackage : alien_wave_sequencer_pkg
`default_nettype wire

// File: rtl/alien_wave_sequencer_move_pacer.sv
`default_nettype none
// ============================================================================
// Module : alien_wave_sequencer_move_pacer
// Brief  : Programmable-interval tick generator. Emits a single registered
//          tick every 'interval' cycles while enabled. Its counter is held at
//          zero while disabled.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   1           system clock
//   reset     in   1           synchronous, active-high
//   enable    in   1           count while high, clear counter while low
//   interval  in   INTERVAL_W  cycles between ticks
//   tick      out  1           1-cycle pulse
// ============================================================================
module alien_wave_sequencer_move_pacer #(
  parameter int INTERVAL_W = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  tick
);

  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic [INTERVAL_W:0]   cnt_next_w;

  // Compare cnt+1 against interval (one bit wider) instead of cnt against
  // interval-1. That avoids an underflow when interval is zero. It also
  // fires at once when the interval has just shrunk below the count.
  assign cnt_next_w = {1'b0, cnt_q} + (INTERVAL_W+1)'(1);

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_next_w >= {1'b0, interval}) begin
      tick_d = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_next_w[INTERVAL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : alien_wave_sequencer_move_pacer
`default_nettype wire

// File: rtl/alien_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alien_wave_sequencer
// Brief  : Game-phase scheduler for the alien formation. It starts waves,
//          pulses the formation reset and paces the march. The march
//          interval shrinks as aliens die and as the wave number rises.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk              in   1       system clock
//   reset            in   1       synchronous, active-high
//   start            in   1       level; a rising edge starts play from IDLE/LOST
//   frame_tick       in   1       1-cycle pulse per video frame
//   shot_hit         in   1       1-cycle pulse, one alien killed
//   formation_over   in   1       level, formation reached the bottom
//   formation_reset  out  1       1-cycle pulse, respawn the formation
//   move_tick        out  1       1-cycle pulse, advance the formation one step
//   alive_count      out  5       aliens remaining this wave
//   wave_num         out  WAVE_W  completed waves (saturating)
//   interval         out  22      current move interval in clk cycles
//   playing          out  1       high in PLAY
//   lost             out  1       high in LOST
// ============================================================================
module alien_wave_sequencer
  import alien_wave_sequencer_pkg::*;
#(
  parameter int N_ALIENS      = AWS_N_ALIENS,
  parameter int BASE_INTERVAL = AWS_BASE_INTERVAL,
  parameter int KILL_STEP     = AWS_KILL_STEP,
  parameter int WAVE_STEP     = AWS_WAVE_STEP,
  parameter int MIN_INTERVAL  = AWS_MIN_INTERVAL,
  parameter int CLEAR_FRAMES  = AWS_CLEAR_FRAMES,
  parameter int WAVE_W        = AWS_WAVE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      frame_tick,
  input  logic                      shot_hit,
  input  logic                      formation_over,
  output logic                      formation_reset,
  output logic                      move_tick,
  output logic [AWS_ALIVE_W-1:0]    alive_count,
  output logic [WAVE_W-1:0]         wave_num,
  output logic [AWS_INTERVAL_W-1:0] interval,
  output logic                      playing,
  output logic                      lost
);

  localparam int PAUSE_W = $clog2(CLEAR_FRAMES + 1);

  wave_state_t               state_q, state_d;
  logic                      start_q;
  logic [AWS_ALIVE_W-1:0]    alive_q, alive_d;
  logic [WAVE_W-1:0]         wave_q, wave_d;
  logic [PAUSE_W-1:0]        pause_q, pause_d;
  logic [AWS_INTERVAL_W-1:0] interval_q, interval_d;
  logic                      formation_reset_q, formation_reset_d;
  logic                      playing_q, playing_d;
  logic                      lost_q, lost_d;

  logic                      start_rise_w;
  logic [AWS_ALIVE_W-1:0]    alive_dec_w;
  logic [AWS_ALIVE_W-1:0]    kills_w;
  logic [AWS_CALC_W-1:0]     raw_interval_w;
  logic                      pacer_en_w;

  assign start_rise_w = start & ~start_q;
  assign alive_dec_w  = (alive_q == '0) ? '0 : alive_q - AWS_ALIVE_W'(1);

  // ---------------------------------------------------------------------
  // Next-state, counters and registered-output decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    wave_d  = wave_q;
    pause_d = pause_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise_w) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // The kill is counted even when formation_over wins the same cycle.
        if (shot_hit) alive_d = alive_dec_w;
        if (formation_over) begin
          state_d = ST_LOST;
        end else if (alive_d == '0) begin
          state_d = ST_CLEAR;
          wave_d  = (wave_q == '1) ? wave_q : wave_q + WAVE_W'(1);
          pause_d = '0;
        end
      end
      ST_CLEAR: begin
        if (frame_tick) begin
          if (pause_q == PAUSE_W'(CLEAR_FRAMES - 1)) state_d = ST_SPAWN;
          else                                       pause_d = pause_q + PAUSE_W'(1);
        end
      end
      ST_LOST: begin
        if (start_rise_w) begin
          state_d = ST_SPAWN;
          wave_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_SPAWN) alive_d = AWS_ALIVE_W'(N_ALIENS);

    // The phase outputs are decoded from the next state. That way they are
    // registered and still line up with state_q.
    formation_reset_d = (state_d == ST_SPAWN);
    playing_d         = (state_d == ST_PLAY);
    lost_d            = (state_d == ST_LOST);
  end

  // ---------------------------------------------------------------------
  // Interval: base minus kill and wave penalties, floored at MIN_INTERVAL.
  // The sum wraps modulo 2^24. The true result always fits in 24-bit
  // signed, so the sign test below is exact.
  // ---------------------------------------------------------------------
  assign kills_w        = AWS_ALIVE_W'(N_ALIENS) - alive_q;
  assign raw_interval_w = AWS_CALC_W'(BASE_INTERVAL)
                        - AWS_CALC_W'(kills_w) * AWS_CALC_W'(KILL_STEP)
                        - AWS_CALC_W'(wave_q)  * AWS_CALC_W'(WAVE_STEP);

  always_comb begin
    interval_d = raw_interval_w[AWS_INTERVAL_W-1:0];
    if ($signed(raw_interval_w) < $signed(AWS_CALC_W'(MIN_INTERVAL)))
      interval_d = AWS_INTERVAL_W'(MIN_INTERVAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      start_q           <= 1'b0;
      alive_q           <= AWS_ALIVE_W'(N_ALIENS);
      wave_q            <= '0;
      pause_q           <= '0;
      interval_q        <= AWS_INTERVAL_W'(BASE_INTERVAL);
      formation_reset_q <= 1'b0;
      playing_q         <= 1'b0;
      lost_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      start_q           <= start;
      alive_q           <= alive_d;
      wave_q            <= wave_d;
      pause_q           <= pause_d;
      interval_q        <= interval_d;
      formation_reset_q <= formation_reset_d;
      playing_q         <= playing_d;
      lost_q            <= lost_d;
    end
  end

  // The pacer runs only while PLAY is both current and next. Its counter is
  // therefore zero on PLAY entry, and its registered tick can only land in a
  // PLAY cycle.
  assign pacer_en_w = (state_q == ST_PLAY) && (state_d == ST_PLAY);

  alien_wave_sequencer_move_pacer #(
    .INTERVAL_W (AWS_INTERVAL_W)
  ) u_move_pacer (
    .clk      (clk),
    .reset    (reset),
    .enable   (pacer_en_w),
    .interval (interval_q),
    .tick     (move_tick)
  );

  assign formation_reset = formation_reset_q;
  assign alive_count     = alive_q;
  assign wave_num        = wave_q;
  assign interval        = interval_q;
  assign playing         = playing_q;
  assign lost            = lost_q;

endmodule : alien_wave_sequencer
`default_nettype wire

// File: tb/tb_alien_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alien_wave_sequencer
// Brief  : Directed self-checking bench for alien_wave_sequencer with
//          reduced pacing constants. Expected values are queued when the
//          stimulus is applied and popped when the DUT response is sampled.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alien_wave_sequencer;

  localparam int BASE  = 100;
  localparam int KSTEP = 5;
  localparam int WSTEP = 10;
  localparam int MINI  = 20;
  localparam int CFR   = 3;
  localparam int NAL   = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic        shot_hit = 1'b0;
  logic        formation_over = 1'b0;
  logic        formation_reset;
  logic        move_tick;
  logic [4:0]  alive_count;
  logic [3:0]  wave_num;
  logic [21:0] interval;
  logic        playing;
  logic        lost;

  int exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  alien_wave_sequencer #(
    .N_ALIENS      (NAL),
    .BASE_INTERVAL (BASE),
    .KILL_STEP     (KSTEP),
    .WAVE_STEP     (WSTEP),
    .MIN_INTERVAL  (MINI),
    .CLEAR_FRAMES  (CFR),
    .WAVE_W        (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .frame_tick      (frame_tick),
    .shot_hit        (shot_hit),
    .formation_over  (formation_over),
    .formation_reset (formation_reset),
    .move_tick       (move_tick),
    .alive_count     (alive_count),
    .wave_num        (wave_num),
    .interval        (interval),
    .playing         (playing),
    .lost            (lost)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input int obs);
    int e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed=%0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  // Steps until move_tick is seen. Returns that step count, or -1 on timeout.
  task automatic wait_tick(input int limit, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      if (!found) begin
        step();
        if (move_tick === 1'b1) begin
          found = 1'b1;
          n = i;
        end
      end
    end
  endtask

  task automatic run_count(input int n, output int ticks, output int resets);
    ticks = 0;
    resets = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (move_tick === 1'b1) ticks++;
      if (formation_reset === 1'b1) resets++;
    end
  endtask

  task automatic hit(input int n);
    for (int i = 0; i < n; i++) begin
      shot_hit = 1'b1; step();
      shot_hit = 1'b0; step();
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
  endtask

  function automatic int model_interval(input int kills, input int wave);
    int r;
    r = BASE - kills * KSTEP - wave * WSTEP;
    return (r < MINI) ? MINI : r;
  endfunction

  initial begin
    int n, t, r;

    // ---------------- T1: reset state, start, pacing ----------------
    repeat (3) step();
    reset = 1'b0;
    step();
    push(0);   chk("rst_formation_reset", formation_reset);
    push(0);   chk("rst_move_tick", move_tick);
    push(NAL); chk("rst_alive", alive_count);
    push(0);   chk("rst_wave", wave_num);
    push(BASE); chk("rst_interval", interval);
    push(0);   chk("rst_playing", playing);
    push(0);   chk("rst_lost", lost);

    start = 1'b1; step();
    push(1); chk("t1_spawn_pulse", formation_reset);
    start = 1'b0; step();
    push(0); chk("t1_spawn_pulse_end", formation_reset);
    push(1); chk("t1_playing", playing);
    push(100); wait_tick(150, n); chk("t1_first_tick", n);
    push(100); wait_tick(150, n); chk("t1_tick_spacing", n);

    // ---------------- T2: four kills shrink the interval ----------------
    hit(3);
    shot_hit = 1'b1; step();
    push(11); chk("t2_alive", alive_count);
    push(model_interval(3, 0)); chk("t2_interval_lag", interval);
    shot_hit = 1'b0; step();
    push(model_interval(4, 0)); chk("t2_interval", interval);
    wait_tick(200, n);
    push(80); wait_tick(200, n); chk("t2_tick_spacing", n);

    // ---------------- T3: wave clear and pause ----------------
    hit(11);
    push(0); chk("t3_alive", alive_count);
    push(1); chk("t3_wave", wave_num);
    push(0); chk("t3_playing", playing);
    hit(1);
    push(0); chk("t3_hit_ignored", alive_count);
    push(0); run_count(20, t, r); chk("t3_no_tick_clear", t);
    frame(); frame();
    push(0); chk("t3_no_early_spawn", formation_reset);
    frame_tick = 1'b1; step();
    push(1); chk("t3_spawn_after_frames", formation_reset);
    frame_tick = 1'b0; step();
    push(1);   chk("t3_playing_again", playing);
    push(NAL); chk("t3_alive_refill", alive_count);
    push(90);  chk("t3_interval_wave1", interval);

    // ---------------- T4: loss and restart edge ----------------
    start = 1'b1; step(); step();
    push(1); chk("t4_start_ignored_play", playing);
    formation_over = 1'b1; step();
    push(1); chk("t4_lost", lost);
    push(0); chk("t4_not_playing", playing);
    run_count(150, t, r);
    push(0); chk("t4_no_tick_lost", t);
    push(0); chk("t4_held_start_no_restart", r);
    start = 1'b0; step();
    start = 1'b1; step();
    push(1); chk("t4_restart_spawn", formation_reset);
    push(0); chk("t4_wave_cleared", wave_num);
    formation_over = 1'b0; step();
    push(1); chk("t4_playing", playing);
    start = 1'b0;

    // ---------------- T5: wave progression and interval floor ----------------
    for (int w = 1; w <= 9; w++) begin
      hit(15);
      frame(); frame(); frame();
      push(w); chk("t5_wave", wave_num);
      push(model_interval(0, w)); chk("t5_wave_interval", interval);
    end
    hit(14);
    push(1);    chk("t5_alive", alive_count);
    push(MINI); chk("t5_floor_interval", interval);
    wait_tick(200, n);
    push(MINI); wait_tick(200, n); chk("t5_floor_spacing", n);

    // ---------------- T6: simultaneous last kill and loss; reset in play ----------------
    shot_hit = 1'b1; formation_over = 1'b1; step();
    shot_hit = 1'b0;
    push(1); chk("t6_lost_wins", lost);
    push(0); chk("t6_alive_zero", alive_count);
    push(9); chk("t6_wave_kept", wave_num);
    step();
    start = 1'b1; formation_over = 1'b0; step();
    step();
    push(1); chk("t6_playing", playing);
    hit(2);
    start = 1'b0; step();
    reset = 1'b1; step();
    push(0);    chk("t6_rst_formation_reset", formation_reset);
    push(0);    chk("t6_rst_move_tick", move_tick);
    push(NAL);  chk("t6_rst_alive", alive_count);
    push(0);    chk("t6_rst_wave", wave_num);
    push(BASE); chk("t6_rst_interval", interval);
    push(0);    chk("t6_rst_playing", playing);
    push(0);    chk("t6_rst_lost", lost);
    reset = 1'b0;
    run_count(10, t, r);
    push(0); chk("t6_idle_no_spawn", r);
    push(0); chk("t6_idle_no_tick", t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alien_wave_sequencer
`default_nettype wire
